// File: rtl/mc_rs_router.sv
// Steers memory-controller responses to per-core show-ahead FIFOs by the core ID
// carried in rtnctl, and returns one registered stall to the MC.
module mc_rs_router #(
  parameter int NUM_CORE        = 4,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int CORE_ID_LSB     = 0,
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_MARGIN    = 2,
  localparam int CID_W          = $clog2(NUM_CORE)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mc_rs_vld,
  input  logic [2:0]                          mc_rs_cmd,
  input  logic [3:0]                          mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]          mc_rs_rtnctl,
  input  logic [63:0]                         mc_rs_data,
  output logic                                mc_rs_stall,
  output logic [NUM_CORE-1:0]                 core_rs_vld,
  output logic [3*NUM_CORE-1:0]               core_rs_cmd,
  output logic [4*NUM_CORE-1:0]               core_rs_scmd,
  output logic [MC_RTNCTL_WIDTH*NUM_CORE-1:0] core_rs_rtnctl,
  output logic [64*NUM_CORE-1:0]              core_rs_data,
  input  logic [NUM_CORE-1:0]                 core_rs_ack,
  output logic                                rs_overflow,
  output logic [CID_W-1:0]                    rs_drop_core
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_W  = 3 + 4 + MC_RTNCTL_WIDTH + 64;
  localparam int STALL_TH = FIFO_DEPTH - STALL_MARGIN;

  logic [CID_W-1:0]    w_core_id;
  logic [ENTRY_W-1:0]  w_entry;
  logic [NUM_CORE-1:0] w_pop;
  logic [NUM_CORE-1:0] w_full;
  logic [NUM_CORE-1:0] w_near_full;
  logic                w_drop;

  logic                r_stall;
  logic                r_overflow;
  logic [CID_W-1:0]    r_drop_core;

  assign w_core_id = mc_rs_rtnctl[CORE_ID_LSB +: CID_W];
  assign w_entry   = {mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data};

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_drop = mc_rs_vld && w_full[w_core_id] && !w_pop[w_core_id];

  for (genvar g = 0; g < NUM_CORE; g++) begin : g_core
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_push;
    logic               w_wr;
    logic [ENTRY_W-1:0] w_head;

    assign w_push    = mc_rs_vld && (w_core_id == CID_W'(g));
    assign w_pop[g]  = core_rs_ack[g] && (r_cnt != '0);
    assign w_full[g] = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_wr      = w_push && (!w_full[g] || w_pop[g]);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr && !w_pop[g])      w_cnt_nxt = r_cnt + 1'b1;
      else if (!w_wr && w_pop[g]) w_cnt_nxt = r_cnt - 1'b1;
    end

    assign w_near_full[g] = (w_cnt_nxt >= CNT_W'(STALL_TH));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_wr)     r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[g]) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cnt <= w_cnt_nxt;
      end
    end

    // NOTE: storage is not reset; the count alone marks which entries are valid.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign core_rs_vld[g] = (r_cnt != '0);
    assign core_rs_data  [64*g +: 64]                           = w_head[63:0];
    assign core_rs_rtnctl[MC_RTNCTL_WIDTH*g +: MC_RTNCTL_WIDTH] = w_head[64 +: MC_RTNCTL_WIDTH];
    assign core_rs_scmd  [4*g +: 4]                             = w_head[64+MC_RTNCTL_WIDTH +: 4];
    assign core_rs_cmd   [3*g +: 3]                             = w_head[68+MC_RTNCTL_WIDTH +: 3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_core <= '0;
    end else begin
      r_stall <= |w_near_full;
      if (w_drop && !r_overflow) begin
        r_overflow  <= 1'b1;
        r_drop_core <= w_core_id;
      end
    end
  end

  assign mc_rs_stall  = r_stall;
  assign rs_overflow  = r_overflow;
  assign rs_drop_core = r_drop_core;

endmodule
